writeback_unit: RTL and testbench



---
 rtl/writeback_unit_pkg.sv | 16 +
 rtl/wb_scoreboard.sv | 61 ++++++
 rtl/writeback_unit.sv | 112 +++++++++++
 tb/tb_writeback_unit.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/writeback_unit_pkg.sv
// Shared definitions for the writeback stage: widths, the zero register and
// the write-port source select.
package writeback_unit_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    NONE  = 2'd0,
    ALU   = 2'd1,
    LDBUF = 2'd2,
    LDIN  = 2'd3
  } wb_src_t;

endpackage

// File: rtl/wb_scoreboard.sv
// Register scoreboard: one busy bit per architectural register (r0 never busy),
// set on accepted issue, cleared on writeback, with the RAW/WAW stall compare.
module wb_scoreboard #(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_rd,
  input  logic [ADDR_W-1:0] src_a,
  input  logic [ADDR_W-1:0] src_b,
  input  logic              clr_valid,
  input  logic [ADDR_W-1:0] clr_rd,
  output logic              issue_stall
);

  localparam int NREG = 2 ** ADDR_W;

  logic [NREG-1:1] busy_r;
  logic [NREG-1:0] busy_s;
  logic [NREG-1:0] busy_nxt_s;
  logic            set_s;

  assign busy_s = {busy_r, 1'b0};
  assign set_s  = issue_valid && !issue_stall && (issue_rd != {ADDR_W{1'b0}});

  // Hazard compare of the issuing instruction against in-flight destinations
  always_comb begin
    issue_stall = 1'b0;
    if (issue_valid) begin
      issue_stall = busy_s[src_a] | busy_s[src_b] | busy_s[issue_rd];
    end else begin
      issue_stall = 1'b0;
    end
  end

  // Next busy vector: clear first, then set, so a same-edge set wins
  always_comb begin
    busy_nxt_s = busy_s;
    if (clr_valid) begin
      busy_nxt_s[clr_rd] = 1'b0;
    end else begin
      busy_nxt_s = busy_s;
    end
    if (set_s) begin
      busy_nxt_s[issue_rd] = 1'b1;
    end else begin
      busy_nxt_s[0] = 1'b0;
    end
  end

  // Busy flop register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r <= '0;
    end else begin
      busy_r <= busy_nxt_s[NREG-1:1];
    end
  end

endmodule

// File: rtl/writeback_unit.sv
// Writeback stage: merges ALU and load results into the single register-file
// write port through a one-entry load skid buffer, and tracks busy registers.
module writeback_unit #(
  parameter int DATA_W = writeback_unit_pkg::DATA_W,
  parameter int ADDR_W = writeback_unit_pkg::ADDR_W
) (
  input  logic              iClk,
  input  logic              nRst,
  input  logic              iIssueValid,
  input  logic [ADDR_W-1:0] iIssueRd,
  input  logic [ADDR_W-1:0] iIssueSrcA,
  input  logic [ADDR_W-1:0] iIssueSrcB,
  output logic              oIssueStall,
  input  logic              iAluValid,
  input  logic [ADDR_W-1:0] iAluRd,
  input  logic [DATA_W-1:0] iAluData,
  input  logic              iLdValid,
  output logic              oLdReady,
  input  logic [ADDR_W-1:0] iLdRd,
  input  logic [DATA_W-1:0] iLdData,
  output logic              oWrite,
  output logic [ADDR_W-1:0] oAddrC,
  output logic [DATA_W-1:0] oRegC
);

  import writeback_unit_pkg::*;

  logic              buf_valid_r;
  logic [ADDR_W-1:0] buf_rd_r;
  logic [DATA_W-1:0] buf_data_r;
  logic              ld_accept_s;
  wb_src_t           sel_s;
  logic [ADDR_W-1:0] sel_rd_s;
  logic [DATA_W-1:0] sel_data_s;

  assign oLdReady    = !buf_valid_r;
  assign ld_accept_s = iLdValid && !buf_valid_r;

  // Write-port source select: ALU, then buffered load, then incoming load
  always_comb begin
    sel_s      = NONE;
    sel_rd_s   = oAddrC;
    sel_data_s = oRegC;
    if (iAluValid) begin
      sel_s      = ALU;
      sel_rd_s   = iAluRd;
      sel_data_s = iAluData;
    end else if (buf_valid_r) begin
      sel_s      = LDBUF;
      sel_rd_s   = buf_rd_r;
      sel_data_s = buf_data_r;
    end else if (ld_accept_s) begin
      sel_s      = LDIN;
      sel_rd_s   = iLdRd;
      sel_data_s = iLdData;
    end else begin
      sel_s      = NONE;
    end
  end

  // Skid buffer: capture a load that loses to the ALU, drain on an ALU-free cycle
  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      buf_valid_r <= 1'b0;
      buf_rd_r    <= '0;
      buf_data_r  <= '0;
    end else if (iAluValid && ld_accept_s) begin
      buf_valid_r <= 1'b1;
      buf_rd_r    <= iLdRd;
      buf_data_r  <= iLdData;
    end else if (sel_s == LDBUF) begin
      buf_valid_r <= 1'b0;
    end else begin
      buf_valid_r <= buf_valid_r;
    end
  end

  // Registered write port; address and data hold on idle cycles
  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      oWrite <= 1'b0;
      oAddrC <= '0;
      oRegC  <= '0;
    end else begin
      case (sel_s)
        NONE: begin
          oWrite <= 1'b0;
        end
        default: begin
          oWrite <= (sel_rd_s != REG_ZERO);
          oAddrC <= sel_rd_s;
          oRegC  <= sel_data_s;
        end
      endcase
    end
  end

  wb_scoreboard #(
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .clk         (iClk),
    .rst_n       (nRst),
    .issue_valid (iIssueValid),
    .issue_rd    (iIssueRd),
    .src_a       (iIssueSrcA),
    .src_b       (iIssueSrcB),
    .clr_valid   (oWrite),
    .clr_rd      (oAddrC),
    .issue_stall (oIssueStall)
  );

endmodule

// File: tb/tb_writeback_unit.sv
// Scoreboard bench for writeback_unit: directed hazard/collision/reset cases
// followed by randomized traffic against a behavioural reference model.
module tb_writeback_unit;

  logic        iClk = 1'b0;
  logic        nRst = 1'b0;
  logic        iIssueValid = 1'b0;
  logic [4:0]  iIssueRd = 5'd0, iIssueSrcA = 5'd0, iIssueSrcB = 5'd0;
  logic        oIssueStall;
  logic        iAluValid = 1'b0;
  logic [4:0]  iAluRd = 5'd0;
  logic [31:0] iAluData = 32'd0;
  logic        iLdValid = 1'b0;
  logic        oLdReady;
  logic [4:0]  iLdRd = 5'd0;
  logic [31:0] iLdData = 32'd0;
  logic        oWrite;
  logic [4:0]  oAddrC;
  logic [31:0] oRegC;

  writeback_unit dut (
    .iClk(iClk), .nRst(nRst),
    .iIssueValid(iIssueValid), .iIssueRd(iIssueRd),
    .iIssueSrcA(iIssueSrcA), .iIssueSrcB(iIssueSrcB), .oIssueStall(oIssueStall),
    .iAluValid(iAluValid), .iAluRd(iAluRd), .iAluData(iAluData),
    .iLdValid(iLdValid), .oLdReady(oLdReady), .iLdRd(iLdRd), .iLdData(iLdData),
    .oWrite(oWrite), .oAddrC(oAddrC), .oRegC(oRegC)
  );

  always #5 iClk = ~iClk;

  int cyc = 0;
  always @(posedge iClk) cyc <= cyc + 1;

  typedef struct {
    int          stamp;
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  errors = 0;
  int  checks = 0;

  // Reference model: architectural busy set, pending-load queue, current write
  bit         m_busy[32];
  wr_t        ld_q[$];
  bit         cur_v = 1'b0;
  logic [4:0] cur_rd = 5'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic bit is_busy(input logic [4:0] r);
    return (r != 5'd0) && m_busy[r];
  endfunction

  task automatic step(input bit iv, input logic [4:0] ird, input logic [4:0] ia,
                      input logic [4:0] ib, input bit av, input logic [4:0] ard,
                      input logic [31:0] ad, input bit lv, input logic [4:0] lrd,
                      input logic [31:0] ldat);
    bit  stall_e;
    bit  acc_ld;
    bit  nw_v;
    wr_t nw;
    @(negedge iClk);
    iIssueValid = iv; iIssueRd = ird; iIssueSrcA = ia; iIssueSrcB = ib;
    iAluValid = av; iAluRd = ard; iAluData = ad;
    iLdValid = lv; iLdRd = lrd; iLdData = ldat;
    #1;
    stall_e = iv && (is_busy(ia) || is_busy(ib) || is_busy(ird));
    chk("issue_stall", 32'(oIssueStall), 32'(stall_e));
    chk("ld_ready", 32'(oLdReady), 32'(ld_q.size() == 0));
    acc_ld = lv && (ld_q.size() == 0);
    nw_v = 1'b1;
    nw = '{0, 5'd0, 32'd0};
    if (av) nw = '{0, ard, ad};
    else if (ld_q.size() > 0) nw = ld_q.pop_front();
    else if (acc_ld) nw = '{0, lrd, ldat};
    else nw_v = 1'b0;
    if (av && acc_ld) ld_q.push_back('{0, lrd, ldat});
    @(posedge iClk);
    #1;
    if (cur_v) m_busy[cur_rd] = 1'b0;
    if (iv && !stall_e && ird != 5'd0) m_busy[ird] = 1'b1;
    cur_v  = nw_v && (nw.rd != 5'd0);
    cur_rd = nw.rd;
    if (cur_v) begin
      nw.stamp = cyc;
      exp_q.push_back(nw);
    end
  endtask

  task automatic idle();
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic model_reset();
    foreach (m_busy[i]) m_busy[i] = 1'b0;
    ld_q.delete();
    exp_q.delete();
    cur_v = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge iClk);
    #2;
    nRst = 1'b0;
    iIssueValid = 1'b0; iAluValid = 1'b0; iLdValid = 1'b0;
    #1;
    chk("rst_write", 32'(oWrite), 32'd0);
    chk("rst_addr", 32'(oAddrC), 32'd0);
    chk("rst_data", oRegC, 32'd0);
    chk("rst_ld_ready", 32'(oLdReady), 32'd1);
    chk("rst_stall", 32'(oIssueStall), 32'd0);
    model_reset();
    repeat (2) @(posedge iClk);
    @(negedge iClk);
    #2;
    nRst = 1'b1;
  endtask

  // Monitor: every presented write must match the oldest expected one, on time
  wr_t mon_e;
  always @(negedge iClk) begin
    if (nRst) begin
      if (oWrite) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got r%0d=%h expected no write (cycle %0d)", oAddrC, oRegC, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          chk("wr_cycle", 32'(cyc), 32'(mon_e.stamp));
          chk("wr_addr", 32'(oAddrC), 32'(mon_e.rd));
          chk("wr_data", oRegC, mon_e.data);
        end
      end else if (exp_q.size() > 0 && exp_q[0].stamp <= cyc) begin
        mon_e = exp_q.pop_front();
        checks++;
        errors++;
        $display("FAIL missing_write: got no write expected r%0d=%h (cycle %0d)", mon_e.rd, mon_e.data, cyc);
      end
    end
  end

  initial begin
    model_reset();
    do_reset();

    // ALU write straight after reset
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
    idle(); idle();

    // RAW on r7: stall until the cycle after the r7 writeback
    step(1'b1, 5'd7, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    repeat (3) step(1'b1, 5'd1, 5'd7, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    step(1'b1, 5'd1, 5'd7, 5'd0, 1'b1, 5'd7, 32'h00000077, 1'b0, 5'd0, 32'd0);
    step(1'b1, 5'd1, 5'd7, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    step(1'b1, 5'd1, 5'd7, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 5'd1, 32'h00000001, 1'b0, 5'd0, 32'd0);
    idle(); idle();

    // ALU/load collision
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 5'd3, 32'h00000011, 1'b1, 5'd4, 32'h00000022);
    idle(); idle();

    // Zero register never stalls and never writes
    step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    step(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 5'd0, 32'h00000055, 1'b0, 5'd0, 32'd0);
    idle(); idle();

    // Spurious r9 writeback coincides with a new issue to r9
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 5'd9, 32'h00000099, 1'b0, 5'd0, 32'd0);
    step(1'b1, 5'd9, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    step(1'b1, 5'd0, 5'd9, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    step(1'b1, 5'd0, 5'd9, 5'd0, 1'b1, 5'd9, 32'h00000909, 1'b0, 5'd0, 32'd0);
    idle(); idle();

    // Reset with r12 busy and the load buffer full
    step(1'b1, 5'd12, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 5'd1, 32'h00000aaa, 1'b1, 5'd2, 32'h00000bbb);
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 5'd3, 32'h00000ccc, 1'b0, 5'd0, 32'd0);
    do_reset();
    step(1'b1, 5'd12, 5'd12, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    idle(); idle();
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 5'd12, 32'h0000000c, 1'b0, 5'd0, 32'd0);
    idle(); idle();

    // Randomized traffic over a narrow register range to provoke hazards
    for (int i = 0; i < 1500; i++) begin
      step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 11)),
           5'($urandom_range(0, 11)), 5'($urandom_range(0, 11)),
           ($urandom_range(0, 99) < 55), 5'($urandom_range(0, 11)), $urandom,
           ($urandom_range(0, 99) < 45), 5'($urandom_range(0, 11)), $urandom);
    end
    repeat (4) idle();
    chk("drain", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
